// File: rtl/reader_pkg.sv
// Shared types and sizing for the FIFO stream reader and its output buffer.
package reader_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} reader_state_e;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry output buffer: head register drives the stream, tail holds the second word.
module reader_skid_buf
  import reader_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [WIDTH-1:0] head,
  output logic             valid
);

  logic [WIDTH-1:0] tail;
  logic [OCC_W-1:0] occ_next;

  assign occ_next = occ + OCC_W'(push) - OCC_W'(pop);

  // head only moves on a pop or when filling an empty buffer, so it is stable under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= '0;
      head  <= '0;
      tail  <= '0;
      valid <= 1'b0;
    end else begin
      occ   <= occ_next;
      valid <= (occ_next != '0);
      if (pop) begin
        if (occ == OCC_W'(BUF_DEPTH)) begin
          head <= tail;
          if (push) tail <= push_data;
        end else if (push) begin
          head <= push_data;
        end
      end else if (push) begin
        if (occ == '0) head <= push_data;
        else           tail <= push_data;
      end
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side consumer presenting words on a valid/ready stream at one word per cycle.
// Optional READER_STATS_EN adds the words_out transfer counter.
module fifo_stream_reader
  import reader_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_underflow
`ifdef READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  words_out
`endif
);

  localparam int unsigned USE_W = OCC_W + 1;

  reader_state_e    state, state_next;
  logic             inflight;
  logic             pop;
  logic             capture;
  logic             credit_ok;
  logic [OCC_W-1:0] occ;
  logic [USE_W-1:0] in_use;

  assign pop     = m_valid & m_ready;
  assign capture = inflight & ~fifo_underflow;
  assign in_use  = USE_W'(occ) + USE_W'(inflight);

  reader_skid_buf #(.WIDTH(FIFO_WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head      (m_data),
    .valid     (m_valid)
  );

  // credit: buffered + in-flight words after this edge's pop must leave room for one more
  always_comb begin
    credit_ok  = (in_use - USE_W'(pop)) < USE_W'(BUF_DEPTH);
    fifo_rd_en = ~rst & (state == RUN) & enable & ~fifo_empty & credit_ok;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = (in_use != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (enable)               state_next = RUN;
        else if (in_use == '0)    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      inflight      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_next;
      inflight      <= fifo_rd_en;
      err_underflow <= err_underflow | (inflight & fifo_underflow);
    end
  end

`ifdef READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)      words_out <= '0;
    else if (pop) words_out <= words_out + CNT_WIDTH'(1);
  end
`else
  logic unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader against a queue-based model of the FIFO and stream.
module tb_fifo_stream_reader;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 16;

  logic         clk = 1'b0;
  logic         rst, enable, fifo_empty, fifo_underflow, fifo_rd_en;
  logic         m_valid, m_ready, err_underflow;
  logic [W-1:0] fifo_data_out, m_data;
`ifdef READER_STATS_EN
  logic [CW-1:0] words_out;
`endif

  fifo_stream_reader #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .err_underflow  (err_underflow)
`ifdef READER_STATS_EN
    ,
    .words_out      (words_out)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: words already captured and awaiting transfer, plus the FIFO contents.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] fifo_q[$];
  int           m_occ;
  bit           m_infl, m_run, m_err;
  int unsigned  m_cnt;
  int           rd_count;
  logic [W-1:0] next_word;

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_word);
      next_word = next_word + W'(1);
    end
  endtask

  // One clock: drive at negedge, check, then advance the model just after posedge.
  task automatic step(input bit en, input bit rdy, input bit r, input int uf_pct, input int fill_pct);
    bit pop, exp_rd, dut_rd;
    int pending;
    @(negedge clk);
    rst        = r;
    enable     = en;
    m_ready    = rdy;
    fifo_empty = (fifo_q.size() == 0);
    #1;
    pop     = (m_occ > 0) && rdy;
    pending = m_occ + int'(m_infl) - int'(pop);
    exp_rd  = !r && m_run && en && (fifo_q.size() > 0) && (pending < 2);
    check("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    check("m_valid", 32'(m_valid), 32'(m_occ > 0));
    if (m_occ > 0) check("m_data", 32'(m_data), 32'(exp_q[0]));
    check("err_underflow", 32'(err_underflow), 32'(m_err));
`ifdef READER_STATS_EN
    check("words_out", 32'(words_out), 32'(CW'(m_cnt)));
`endif
    dut_rd = fifo_rd_en;
    if (dut_rd) rd_count++;
    @(posedge clk);
    #1;
    if (r) begin
      m_occ  = 0;
      m_infl = 1'b0;
      m_run  = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 0;
      exp_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_occ--;
        m_cnt++;
      end
      if (m_infl) begin
        if (fifo_underflow) m_err = 1'b1;
        else begin
          exp_q.push_back(fifo_data_out);
          m_occ++;
        end
      end
      // reads are allowed in the cycle after enable is seen high, and only then
      m_run  = en;
      m_infl = exp_rd;
    end
    if (dut_rd && fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
    else                             fifo_data_out = W'($urandom);
    fifo_underflow = dut_rd && !r && (int'($urandom_range(99)) < uf_pct);
    if (int'($urandom_range(99)) < fill_pct) fill(1);
  endtask

  logic [W-1:0] first_word;

  initial begin
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
    fifo_underflow = 1'b0; fifo_data_out = '0;
    m_occ = 0; m_infl = 1'b0; m_run = 1'b0; m_err = 1'b0; m_cnt = 0;
    rd_count = 0; next_word = W'(1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(fifo_rd_en), 32'(0));
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_m_data", 32'(m_data), 32'(0));
    check("rst_err", 32'(err_underflow), 32'(0));

    // four preloaded words stream straight through
    fill(4);
    rd_count = 0;
    repeat (8) step(1'b1, 1'b1, 1'b0, 0, 0);
    check("burst4_reads", 32'(rd_count), 32'(4));
`ifdef READER_STATS_EN
    check("burst4_words_out", 32'(words_out), 32'(4));
`endif

    // backpressure: only two reads, head held
    first_word = next_word;
    fill(8);
    rd_count = 0;
    repeat (6) step(1'b1, 1'b0, 1'b0, 0, 0);
    check("bp_reads", 32'(rd_count), 32'(2));
    check("bp_head", 32'(m_data), 32'(first_word));
    check("bp_valid", 32'(m_valid), 32'(1));
    repeat (10) step(1'b1, 1'b1, 1'b0, 0, 0);
    check("bp_total_reads", 32'(rd_count), 32'(8));

    // empty FIFO: nothing happens
    rd_count = 0;
    repeat (8) step(1'b1, 1'b1, 1'b0, 0, 0);
    check("empty_reads", 32'(rd_count), 32'(0));
    check("empty_valid", 32'(m_valid), 32'(0));
    check("empty_err", 32'(err_underflow), 32'(0));

    // every read answered by underflow: words dropped, error sticks until reset
    fill(6);
    rd_count = 0;
    repeat (10) step(1'b1, 1'b1, 1'b0, 100, 0);
    check("uf_reads", 32'(rd_count), 32'(6));
    check("uf_err", 32'(err_underflow), 32'(1));
    check("uf_no_data", 32'(m_valid), 32'(0));
    fill(2);
    repeat (6) step(1'b1, 1'b1, 1'b0, 0, 0);
    check("uf_err_sticky", 32'(err_underflow), 32'(1));
    step(1'b0, 1'b0, 1'b1, 0, 0);
    check("uf_err_cleared", 32'(err_underflow), 32'(0));

    // drain: fill buffer under stall, drop enable, both words still delivered
    fill(6);
    repeat (4) step(1'b1, 1'b0, 1'b0, 0, 0);
    check("drain_full", 32'(m_valid), 32'(1));
    rd_count = 0;
    repeat (5) step(1'b0, 1'b1, 1'b0, 0, 0);
    check("drain_reads", 32'(rd_count), 32'(0));
    check("drain_empty", 32'(m_valid), 32'(0));

    // reset in the middle of streaming, then resume
    fill(8);
    repeat (4) step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 0, 0);
    check("midrst_valid", 32'(m_valid), 32'(0));
`ifdef READER_STATS_EN
    check("midrst_words_out", 32'(words_out), 32'(0));
`endif
    repeat (12) step(1'b1, 1'b1, 1'b0, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(int'($urandom_range(99)) < 80, int'($urandom_range(99)) < 65,
           $urandom_range(199) == 0, 3, 60);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
